// File: rtl/arkanoid_pkg.sv
// Shared Arkanoid definitions: serve controller state encoding and default clock/tick rates.
package arkanoid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    COUNT  = 2'd2,
    LAUNCH = 2'd3
  } serve_state_t;

  localparam int DEFAULT_CLK_HZ  = 25_000_000;
  localparam int DEFAULT_TICK_HZ = 60;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV enabled cycles; holds while disabled.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= (count == LAST) ? '0 : count + 1'b1;
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/serve_countdown_ctrl.sv
// Serve countdown controller: kicks the countdown timer, feeds it ticks, and
// holds the ball on the paddle until the timer reports zero.
module serve_countdown_ctrl
  import arkanoid_pkg::*;
#(
  parameter int CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int TICK_HZ    = DEFAULT_TICK_HZ,
  parameter int COUNT_SECS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serve_req,
  input  logic       pause,
  input  logic       timer_up,
  output logic       timer_start,
  output logic       timer_tick,
  output logic       ball_hold,
  output logic       ball_launch,
  output logic [1:0] count_digit,
  output logic       busy
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int SW  = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
  localparam logic [SW-1:0] SUB_LAST  = SW'(TICK_HZ - 1);
  localparam logic [1:0]    DIGIT_TOP = 2'(COUNT_SECS);

  serve_state_t state, next_state;
  logic [SW-1:0] sub_cnt;
  logic [1:0]    digit;
  logic          presc_clear;
  logic          presc_en;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (presc_clear),
    .enable (presc_en),
    .tick   (timer_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // A serve request restarts from any state except START itself; in START the
  // timer_up input is still the stale zero from the previous run and is ignored.
  always_comb begin
    next_state  = state;
    timer_start = 1'b0;
    ball_hold   = 1'b0;
    ball_launch = 1'b0;
    busy        = 1'b0;
    count_digit = 2'd0;
    presc_clear = 1'b0;
    presc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (serve_req)
          next_state = START;
      end
      START: begin
        timer_start = 1'b1;
        ball_hold   = 1'b1;
        busy        = 1'b1;
        count_digit = DIGIT_TOP;
        presc_clear = 1'b1;
        next_state  = COUNT;
      end
      COUNT: begin
        ball_hold   = 1'b1;
        busy        = 1'b1;
        count_digit = digit;
        presc_en    = !pause;
        if (serve_req)
          next_state = START;
        else if (timer_up)
          next_state = LAUNCH;
      end
      LAUNCH: begin
        ball_launch = 1'b1;
        busy        = 1'b1;
        next_state  = serve_req ? START : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One HUD digit per TICK_HZ ticks; the digit bottoms out at 1 while waiting for timer_up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_cnt <= '0;
      digit   <= 2'd0;
    end else if (state == START) begin
      sub_cnt <= '0;
      digit   <= DIGIT_TOP;
    end else if (timer_tick) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        if (digit > 2'd1)
          digit <= digit - 2'd1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serve_countdown_ctrl.sv
// Bench for serve_countdown_ctrl: a 180-count timer model, a vector table,
// directed serve sequences and a randomized run against a reference model.
module tb_serve_countdown_ctrl;

  localparam int CLK_HZ     = 600;
  localparam int TICK_HZ    = 60;
  localparam int COUNT_SECS = 3;
  localparam int DIV        = CLK_HZ / TICK_HZ;
  localparam int LOAD       = TICK_HZ * COUNT_SECS;
  localparam int LAUNCH_LAT = LOAD * DIV + 2;

  typedef struct {
    logic       serve;
    logic       pause;
    logic       t_start;
    logic       tick;
    logic       hold;
    logic       launch;
    logic [1:0] digit;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       serve_req;
  logic       pause;
  logic       timer_up;
  logic       timer_start;
  logic       timer_tick;
  logic       ball_hold;
  logic       ball_launch;
  logic [1:0] count_digit;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tcount = 0;
  int m_phase = 0;
  int m_run = 0;
  int m_ticks = 0;
  int launch_cnt, first_launch, start_cnt, busy_drops;
  vec_t tab[15];
  vec_t none;

  serve_countdown_ctrl #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .COUNT_SECS(COUNT_SECS)
  ) dut (
    .clk(clk), .reset(reset), .serve_req(serve_req), .pause(pause),
    .timer_up(timer_up), .timer_start(timer_start), .timer_tick(timer_tick),
    .ball_hold(ball_hold), .ball_launch(ball_launch),
    .count_digit(count_digit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Countdown timer the controller drives: reload on start, decrement per tick.
  always @(posedge clk) begin
    if (timer_start)
      tcount <= LOAD;
    else if (timer_tick && tcount > 0)
      tcount <= tcount - 1;
  end
  assign timer_up = (tcount == 0);

  function automatic vec_t mkv(logic s, logic p, logic ts, logic tk, logic h,
                               logic l, int d, logic b);
    vec_t v;
    v.serve = s; v.pause = p; v.t_start = ts; v.tick = tk;
    v.hold = h; v.launch = l; v.digit = 2'(d); v.busy = b;
    return v;
  endfunction

  // Phases: 0 idle, 1 start, 2 counting, 3 launch; ticks derived from elapsed unpaused cycles.
  function automatic vec_t model_expect(logic s, logic p);
    int shown;
    shown = m_ticks / TICK_HZ;
    if (shown > COUNT_SECS - 1) shown = COUNT_SECS - 1;
    case (m_phase)
      1: return mkv(s, p, 1, 0, 1, 0, COUNT_SECS, 1);
      2: return mkv(s, p, 0, !p && (m_run % DIV == DIV - 1), 1, 0, COUNT_SECS - shown, 1);
      3: return mkv(s, p, 0, 0, 0, 1, 0, 1);
      default: return mkv(s, p, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  task automatic model_advance(input logic s, input logic p, input logic tu);
    case (m_phase)
      0: if (s) m_phase = 1;
      1: begin m_phase = 2; m_run = 0; m_ticks = 0; end
      2: begin
        if (s) m_phase = 1;
        else if (tu) m_phase = 3;
        else if (!p) begin
          if (m_run % DIV == DIV - 1) m_ticks++;
          m_run++;
        end
      end
      default: m_phase = s ? 1 : 0;
    endcase
  endtask

  task automatic checkOutput(input string name, input vec_t e);
    total++;
    if (timer_start !== e.t_start || timer_tick !== e.tick || ball_hold !== e.hold ||
        ball_launch !== e.launch || count_digit !== e.digit || busy !== e.busy) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got start=%b tick=%b hold=%b launch=%b digit=%0d busy=%b want start=%b tick=%b hold=%b launch=%b digit=%0d busy=%b",
               name, cyc, timer_start, timer_tick, ball_hold, ball_launch, count_digit, busy,
               e.t_start, e.tick, e.hold, e.launch, e.digit, e.busy);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Entered just after a rising edge: drive, settle, compare, then advance one clock.
  task automatic applyStimulus(input logic s, input logic p, input logic use_tab,
                               input vec_t tv, input string name);
    logic tu;
    serve_req = s;
    pause = p;
    #1;
    checkOutput(name, use_tab ? tv : model_expect(s, p));
    if (ball_launch) begin
      launch_cnt++;
      if (first_launch < 0) first_launch = cyc;
    end
    if (timer_start) start_cnt++;
    if (!busy) busy_drops++;
    tu = timer_up;
    @(posedge clk);
    model_advance(s, p, tu);
    cyc++;
    #1;
  endtask

  task automatic runCycles(input int n, input int p_from, input int p_len, input string name);
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, (cyc >= p_from) && (cyc < p_from + p_len), 1'b0, none, name);
  endtask

  task automatic clearEvents();
    launch_cnt = 0; first_launch = -1; start_cnt = 0; busy_drops = 0;
  endtask

  initial begin
    int s0, r0;
    logic pz;
    none = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; serve_req = 1'b0; pause = 1'b0;
    clearEvents();

    tab[0] = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    tab[1] = mkv(1, 0, 0, 0, 0, 0, 0, 0);
    tab[2] = mkv(1, 0, 1, 0, 1, 0, 3, 1);
    tab[3] = mkv(0, 1, 0, 0, 1, 0, 3, 1);
    for (int i = 4; i <= 12; i++) tab[i] = mkv(0, 0, 0, 0, 1, 0, 3, 1);
    tab[13] = mkv(0, 0, 0, 1, 1, 0, 3, 1);
    tab[14] = mkv(0, 1, 0, 0, 1, 0, 3, 1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", none);
    reset = 1'b1;

    for (int i = 0; i < 15; i++)
      applyStimulus(tab[i].serve, tab[i].pause, 1'b1, tab[i], "vector");

    // Plain countdown, no pause.
    clearEvents();
    applyStimulus(1'b1, 1'b0, 1'b0, none, "t2_serve");
    s0 = cyc;
    runCycles(LAUNCH_LAT + 1, 0, 0, "t2_run");
    checkInt("t2_start_once", start_cnt, 1);
    checkInt("t2_launch_cycle", first_launch - s0, LAUNCH_LAT);
    checkInt("t2_launch_once", launch_cnt, 1);

    // Pause 50 cycles mid-count delays launch by 50.
    clearEvents();
    applyStimulus(1'b1, 1'b0, 1'b0, none, "t3_serve");
    s0 = cyc;
    runCycles(LAUNCH_LAT + 51, s0 + 200, 50, "t3_run");
    checkInt("t3_launch_cycle", first_launch - s0, LAUNCH_LAT + 50);

    // Restart while digit shows 2.
    clearEvents();
    applyStimulus(1'b1, 1'b0, 1'b0, none, "t4_serve");
    s0 = cyc;
    runCycles(700, 0, 0, "t4_run");
    checkInt("t4_digit_before_restart", count_digit, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, none, "t4_reserve");
    r0 = cyc;
    runCycles(LAUNCH_LAT + 1, 0, 0, "t4_run2");
    checkInt("t4_launch_cycle", first_launch - r0, LAUNCH_LAT);
    checkInt("t4_starts", start_cnt, 2);

    // Serve colliding with the first timer_up cycle.
    clearEvents();
    applyStimulus(1'b1, 1'b0, 1'b0, none, "t5_serve");
    s0 = cyc;
    runCycles(LOAD * DIV + 1, 0, 0, "t5_run");
    checkInt("t5_timer_up_at_serve", int'(timer_up), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, none, "t5_reserve");
    r0 = cyc;
    runCycles(LAUNCH_LAT + 1, 0, 0, "t5_run2");
    checkInt("t5_launch_cycle", first_launch - r0, LAUNCH_LAT);
    checkInt("t5_launch_once", launch_cnt, 1);

    // Back-to-back: serve during LAUNCH.
    clearEvents();
    applyStimulus(1'b1, 1'b0, 1'b0, none, "t6_serve");
    busy_drops = 0;
    runCycles(LAUNCH_LAT, 0, 0, "t6_run");
    checkInt("t6_in_launch", int'(ball_launch), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, none, "t6_reserve");
    runCycles(LAUNCH_LAT + 1, 0, 0, "t6_run2");
    checkInt("t6_starts", start_cnt, 2);
    checkInt("t6_launches", launch_cnt, 2);
    checkInt("t6_busy_drops", busy_drops, 0);

    // Asynchronous reset in the middle of a countdown.
    applyStimulus(1'b1, 1'b0, 1'b0, none, "t1_serve");
    runCycles(30, 0, 0, "t1_run");
    reset = 1'b0;
    #1;
    checkOutput("t1_async_reset", none);
    m_phase = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clearEvents();
    runCycles(5, 0, 0, "t1_after_reset");
    checkInt("t1_no_start", start_cnt, 0);

    // Randomized serves and pause bursts against the reference model.
    pz = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 99) == 0) pz = ~pz;
      applyStimulus($urandom_range(0, 399) == 0, pz, 1'b0, none, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
